clause_scanner: RTL and testbench

//  Sequential driver of the clause-evaluation path. Given one integer assignment y1..yN, it

---
 rtl/clause_scanner_pkg.sv | 25 ++
 rtl/clause_scanner_if.sv | 11 +
 rtl/clause_scanner_eval.sv | 29 ++
 rtl/clause_scanner.sv | 173 +++++++++++++++++
 tb/tb_clause_scanner.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/clause_scanner_pkg.sv
// Shared widths, FSM encoding and count clamping for the clause scanner.
// NUM_VARS / BW play the role of NUMBER_OF_INTEGER_VARIABLES / BIT_WIDTH_OF_INTEGER_VARIABLE.
package clause_scanner_pkg;

    localparam int NUM_VARS = 2;
    localparam int BW       = 8;

    localparam int NUM_CLAUSES = 16;
    localparam int AW          = $clog2(NUM_CLAUSES);
    localparam int CW          = $clog2(NUM_CLAUSES + 1);
    localparam int DW          = (NUM_VARS + 1) * BW;
    localparam int YW          = NUM_VARS * BW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
        return (c > CW'(NUM_CLAUSES)) ? CW'(NUM_CLAUSES) : c;
    endfunction

endpackage

// File: rtl/clause_scanner_if.sv
// Clause-memory read port: address/strobe out of the scanner, {b, aN..a1} back one cycle later.
interface clause_scanner_if;
    import clause_scanner_pkg::*;

    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_data;

    modport master (output mem_addr, output mem_rd_en, input mem_data);
    modport slave  (input mem_addr, input mem_rd_en, output mem_data);
endinterface

// File: rtl/clause_scanner_eval.sv
// Combinational clause check: unsat = (a1*y1 + .. + aN*yN) > b, everything two's complement.
module clause_scanner_eval
    import clause_scanner_pkg::*;
(
    input  logic [DW-1:0] clause,
    input  logic [YW-1:0] assignment,
    output logic          unsat
);
    // Wide enough that no product or partial sum can overflow.
    localparam int SW = 2 * BW + $clog2(NUM_VARS) + 1;

    logic signed [SW-1:0] acc [NUM_VARS+1];
    logic signed [SW-1:0] b_ext;

    assign acc[0] = '0;

    generate
        for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_term
            logic signed [SW-1:0] a_ext;
            logic signed [SW-1:0] y_ext;
            assign a_ext      = SW'($signed(clause[gi*BW +: BW]));
            assign y_ext      = SW'($signed(assignment[gi*BW +: BW]));
            assign acc[gi+1]  = acc[gi] + a_ext * y_ext;
        end
    endgenerate

    assign b_ext = SW'($signed(clause[NUM_VARS*BW +: BW]));
    assign unsat = acc[NUM_VARS] > b_ext;
endmodule

// File: rtl/clause_scanner.sv
// Streams every stored clause for one assignment and reports unsat count / first unsat index.
// Optional SCAN_EARLY_EXIT_EN: stop at the first unsat clause and report unsat_count = 1.
module clause_scanner
    import clause_scanner_pkg::*;
(
    input  logic             in_clk,
    input  logic             in_reset,
    input  logic             in_enable,
    input  logic             in_start,
    input  logic [CW-1:0]    in_clause_count,
    input  logic [YW-1:0]    in_current_assignment,
    clause_scanner_if.master mem,
    output logic             out_busy,
    output logic             out_done,
    output logic [CW-1:0]    out_unsat_count,
    output logic             out_all_sat,
    output logic [AW-1:0]    out_first_unsat,
    output logic             out_first_unsat_valid
);
    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          rd_en_reg, rd_en_next;
    logic [CW-1:0] count_reg, count_next;
    logic [YW-1:0] assign_reg, assign_next;
    logic [AW-1:0] eval_idx_reg, eval_idx_next;
    logic          ret_reg;
    logic [DW-1:0] hold_reg, hold_next;
    logic          hold_valid_reg, hold_valid_next;
    logic [CW-1:0] unsat_reg, unsat_next;
    logic [AW-1:0] first_reg, first_next;
    logic          first_valid_reg, first_valid_next;
    logic          all_sat_reg, all_sat_next;
    logic          done_reg, done_next;

    logic          rd_fire;
    logic          scanning;
    logic          eval_valid;
    logic [DW-1:0] eval_data;
    logic          clause_unsat;
    logic [CW-1:0] start_count;

    assign rd_fire     = rd_en_reg & in_enable;
    assign scanning    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    // A return that landed during a stall waits in the hold register.
    assign eval_valid  = ret_reg | hold_valid_reg;
    assign eval_data   = hold_valid_reg ? hold_reg : mem.mem_data;
    assign start_count = clamp_count(in_clause_count);

    clause_scanner_eval u_eval (
        .clause     (eval_data),
        .assignment (assign_reg),
        .unsat      (clause_unsat)
    );

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        rd_en_next       = rd_en_reg;
        count_next       = count_reg;
        assign_next      = assign_reg;
        eval_idx_next    = eval_idx_reg;
        hold_next        = hold_reg;
        hold_valid_next  = hold_valid_reg;
        unsat_next       = unsat_reg;
        first_next       = first_reg;
        first_valid_next = first_valid_reg;
        all_sat_next     = all_sat_reg;
        done_next        = 1'b0;

        if (!in_enable) begin
            if (ret_reg && scanning) begin
                hold_next       = mem.mem_data;
                hold_valid_next = 1'b1;
            end
        end else begin
            hold_valid_next = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_start) begin
                        count_next       = start_count;
                        assign_next      = in_current_assignment;
                        eval_idx_next    = '0;
                        unsat_next       = '0;
                        first_next       = '0;
                        first_valid_next = 1'b0;
                        all_sat_next     = 1'b0;
                        addr_next        = '0;
                        if (start_count == '0) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_RUN;
                            rd_en_next = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (addr_reg == AW'(count_reg - CW'(1))) begin
                        rd_en_next = 1'b0;
                        state_next = ST_DRAIN;
                    end else begin
                        addr_next = addr_reg + AW'(1);
                    end
                end
                ST_DRAIN: state_next = ST_DONE;
                ST_DONE: begin
                    state_next   = ST_IDLE;
                    done_next    = 1'b1;
                    all_sat_next = (unsat_reg == '0);
                end
                default: state_next = ST_IDLE;
            endcase

            if (scanning && eval_valid) begin
                eval_idx_next = eval_idx_reg + AW'(1);
                if (clause_unsat) begin
                    unsat_next = unsat_reg + CW'(1);
                    if (!first_valid_reg) begin
                        first_next       = eval_idx_reg;
                        first_valid_next = 1'b1;
                    end
`ifdef SCAN_EARLY_EXIT_EN
                    // The read issued on this edge is simply never evaluated.
                    rd_en_next = 1'b0;
                    state_next = ST_DONE;
`endif
                end
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            rd_en_reg       <= 1'b0;
            count_reg       <= '0;
            assign_reg      <= '0;
            eval_idx_reg    <= '0;
            ret_reg         <= 1'b0;
            hold_reg        <= '0;
            hold_valid_reg  <= 1'b0;
            unsat_reg       <= '0;
            first_reg       <= '0;
            first_valid_reg <= 1'b0;
            all_sat_reg     <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            rd_en_reg       <= rd_en_next;
            count_reg       <= count_next;
            assign_reg      <= assign_next;
            eval_idx_reg    <= eval_idx_next;
            ret_reg         <= rd_fire;
            hold_reg        <= hold_next;
            hold_valid_reg  <= hold_valid_next;
            unsat_reg       <= unsat_next;
            first_reg       <= first_next;
            first_valid_reg <= first_valid_next;
            all_sat_reg     <= all_sat_next;
            done_reg        <= done_next;
        end
    end

    assign mem.mem_addr          = addr_reg;
    assign mem.mem_rd_en         = rd_fire;
    assign out_busy              = (state_reg != ST_IDLE);
    assign out_done              = done_reg;
    assign out_unsat_count       = unsat_reg;
    assign out_all_sat           = all_sat_reg;
    assign out_first_unsat       = first_reg;
    assign out_first_unsat_valid = first_valid_reg;
endmodule

// File: tb/tb_clause_scanner.sv
// Directed bench for clause_scanner (NUM_VARS=2, BW=8); memory returns junk on non-read cycles.
module tb_clause_scanner;
    import clause_scanner_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_enable;
    logic          in_start;
    logic [4:0]    in_count;
    logic [15:0]   in_y;
    logic          out_busy, out_done, out_all_sat, out_first_unsat_valid;
    logic [4:0]    out_unsat_count;
    logic [3:0]    out_first_unsat;

    logic [23:0]   mem [16];
    logic [23:0]   mem_q;

    int errors = 0;
    int checks = 0;
    int lat_seen, rd_seen, max_addr_seen;

    clause_scanner_if bus ();

    clause_scanner dut (
        .in_clk                (clk),
        .in_reset              (rst_n),
        .in_enable             (in_enable),
        .in_start              (in_start),
        .in_clause_count       (in_count),
        .in_current_assignment (in_y),
        .mem                   (bus),
        .out_busy              (out_busy),
        .out_done              (out_done),
        .out_unsat_count       (out_unsat_count),
        .out_all_sat           (out_all_sat),
        .out_first_unsat       (out_first_unsat),
        .out_first_unsat_valid (out_first_unsat_valid)
    );

    always #5 clk = ~clk;

    // b=-128, a=127,127: unsat for y=(1,1), so a stale read would be visible.
    always @(posedge clk) mem_q <= bus.mem_rd_en ? mem[bus.mem_addr] : 24'h807F7F;
    assign bus.mem_data = mem_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic note_rd();
        if (bus.mem_rd_en) begin
            rd_seen++;
            if (int'(bus.mem_addr) > max_addr_seen) max_addr_seen = int'(bus.mem_addr);
        end
    endtask

    task automatic fill(input logic [23:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic run_scan(input logic [4:0] c, input logic [15:0] yy,
                            input int stall_at, input int restart_at);
        in_start = 1'b1;
        in_count = c;
        in_y     = yy;
        rd_seen = 0; max_addr_seen = 0; lat_seen = 0;
        @(posedge clk); #1;
        in_start = 1'b0;
        note_rd();
        for (int n = 1; n <= 100; n++) begin
            if (stall_at > 0 && n == stall_at)     in_enable = 1'b0;
            if (stall_at > 0 && n == stall_at + 3) in_enable = 1'b1;
            if (restart_at > 0 && n == restart_at) begin
                in_start = 1'b1; in_count = 5'd1; in_y = 16'hFFFF;
            end
            if (restart_at > 0 && n == restart_at + 1) in_start = 1'b0;
            @(posedge clk); #1;
            note_rd();
            if (out_done) begin
                lat_seen = n;
                break;
            end
        end
        in_enable = 1'b1;
        in_start  = 1'b0;
        $display("scan count=%0d y=%h stall_at=%0d -> lat=%0d unsat=%0d first=%0d/%0b all_sat=%0b",
                 c, yy, stall_at, lat_seen, out_unsat_count, out_first_unsat,
                 out_first_unsat_valid, out_all_sat);
    endtask

    task automatic check_res(input string tag, input int lat, input int unsat,
                             input int first, input logic fvalid, input logic all_sat);
        check({tag, "_lat"},     lat_seen, lat);
        check({tag, "_unsat"},   out_unsat_count, unsat);
        check({tag, "_first"},   out_first_unsat, first);
        check({tag, "_fvalid"},  out_first_unsat_valid, fvalid);
        check({tag, "_all_sat"}, out_all_sat, all_sat);
    endtask

    initial begin
        rst_n = 1'b0; in_enable = 1'b1; in_start = 1'b0; in_count = '0; in_y = '0;
        fill(24'h7F0101);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  out_busy, 0);
        check("rst_done",  out_done, 0);
        check("rst_unsat", out_unsat_count, 0);
        check("rst_allsat", out_all_sat, 0);
        check("rst_rd_en", bus.mem_rd_en, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clause 0 satisfied (2<=2), clause 1 violated (2>1).
        mem[0] = 24'h020101; mem[1] = 24'h010101;
        run_scan(5'd2, 16'h0101, 0, 0);
        check_res("t1", 4, 1, 1, 1'b1, 1'b0);
        check("t1_busy_at_done", out_busy, 0);
        @(posedge clk); #1;
        check("t1_done_pulse", out_done, 0);
        check("t1_held_unsat", out_unsat_count, 1);

        run_scan(5'd2, 16'hFFFF, 0, 0);
        check_res("t2", 4, 0, 0, 1'b0, 1'b1);

        run_scan(5'd0, 16'h0101, 0, 0);
        check_res("t3_zero", 1, 0, 0, 1'b0, 1'b1);
        check("t3_zero_no_rd", rd_seen, 0);

        fill(24'h7F0101);
        run_scan(5'd16, 16'h0101, 0, 0);
        check_res("t3_full", 18, 0, 0, 1'b0, 1'b1);
        check("t3_full_max_addr", max_addr_seen, 15);

        // Clauses 3 and 5 violated (2 > 0).
        mem[3] = 24'h000101; mem[5] = 24'h000101;
        run_scan(5'd8, 16'h0101, 0, 0);
        check_res("t4_plain", 10, 2, 3, 1'b1, 1'b0);
        run_scan(5'd8, 16'h0101, 3, 0);
        check_res("t4_stall", 13, 2, 3, 1'b1, 1'b0);

        run_scan(5'd20, 16'h0101, 0, 0);
        check_res("clamp", 18, 2, 3, 1'b1, 1'b0);

        // Reset in the middle of a scan.
        in_start = 1'b1; in_count = 5'd8; in_y = 16'h0101;
        @(posedge clk); #1;
        in_start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.mem_addr == 4'd5) break;
            @(posedge clk); #1;
        end
        check("t5_reached_addr5", bus.mem_addr, 5);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy",   out_busy, 0);
        check("t5_rst_addr",   bus.mem_addr, 0);
        check("t5_rst_rd_en",  bus.mem_rd_en, 0);
        check("t5_rst_unsat",  out_unsat_count, 0);
        check("t5_rst_fvalid", out_first_unsat_valid, 0);
        @(posedge clk); #1;
        check("t5_rst_no_done", out_done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_scan(5'd8, 16'h0101, 0, 3);
        check_res("t5_restart", 10, 2, 3, 1'b1, 1'b0);

`ifdef SCAN_EARLY_EXIT_EN
        mem[0] = 24'h020101; mem[1] = 24'h010101;
        for (int i = 2; i < 16; i++) mem[i] = 24'h000101;
        run_scan(5'd8, 16'h0101, 0, 0);
        check_res("t6_early", 4, 1, 1, 1'b1, 1'b0);
        check("t6_max_addr", max_addr_seen, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
